// File: rtl/titan_defines_pkg.sv
// Shared titan definitions: fetch-port state encoding, the default NOP
// instruction word and the Wishbone response decode.
package titan_defines_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] TITAN_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2,
        ST_HOLD    = 2'd3
    } imem_state_e;

    typedef enum logic [1:0] {
        WB_RSP_NONE    = 2'd0,
        WB_RSP_ACK     = 2'd1,
        WB_RSP_ERR     = 2'd2,
        WB_RSP_TIMEOUT = 2'd3
    } wb_rsp_e;

    // err dominates ack when both are asserted; a timeout only counts when
    // the slave said nothing this cycle.
    function automatic wb_rsp_e wb_decode(input logic ack,
                                          input logic err,
                                          input logic expired);
        if (err) begin
            return WB_RSP_ERR;
        end else if (ack) begin
            return WB_RSP_ACK;
        end else if (expired) begin
            return WB_RSP_TIMEOUT;
        end
        return WB_RSP_NONE;
    endfunction

endpackage

// File: rtl/titan_bus_timer.sv
// Saturating bus-cycle timer. Counts while enabled, flags expiry once it
// reaches TIMEOUT_CYCLES-1 and stays there until cleared.
module titan_bus_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;

    // Count up while enabled, saturating at the last cycle before timeout.
    always_ff @(posedge clk_i) begin
        // NOTE: registered state is always written with <= so every flop
        // samples the pre-edge values, independent of block ordering.
        if (rst_i || clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expired_o = (count_q == CNT_MAX);

endmodule

// File: rtl/titan_imem_port.sv
// Instruction-fetch port: turns IF-stage PC requests into single Wishbone
// read cycles, delivers the word (or a fault) back to IF, buffers it when the
// consumer is stalled and drops it when the pipeline flushes.
module titan_imem_port
    import titan_defines_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] NOP_INST       = TITAN_NOP_INST
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        fetch_en_i,
    input  logic        flush_i,
    output logic [31:0] instruction_o,
    output logic        inst_access_fault_o,
    output logic        stall_o,
    output logic [31:0] iport_addr_o,
    output logic        iport_cyc_o,
    output logic        iport_stb_o,
    input  logic [31:0] iport_dat_i,
    input  logic        iport_ack_i,
    input  logic        iport_err_i
);

    imem_state_e state_q;
    imem_state_e state_d;
    logic [31:0] addr_q;
    logic [31:0] buf_inst_q;
    logic        buf_fault_q;

    logic        load_addr;
    logic        capture;
    logic        req_ok;
    logic        bus_active;
    logic        timer_clear;
    logic        timer_expired;
    wb_rsp_e     rsp;
    logic        rsp_event;
    logic [31:0] rsp_inst;
    logic        rsp_fault;

    // Misaligned PCs never reach the bus; IF raises that trap itself.
    assign req_ok     = fetch_en_i && !flush_i && (pc_i[1:0] == 2'b00);
    assign bus_active = (state_q == ST_WAIT) || (state_q == ST_DISCARD);

    // The timeout window covers the whole bus cycle, including any discard
    // tail after a flush, so it is only cleared while no cycle is open.
    assign timer_clear = (state_q == ST_IDLE) || (state_q == ST_HOLD);

    titan_bus_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (timer_clear),
        .enable_i  (bus_active),
        .expired_o (timer_expired)
    );

    assign rsp       = wb_decode(iport_ack_i, iport_err_i, timer_expired);
    assign rsp_event = (rsp != WB_RSP_NONE);
    assign rsp_inst  = (rsp == WB_RSP_ACK) ? iport_dat_i : NOP_INST;
    assign rsp_fault = (rsp == WB_RSP_ERR) || (rsp == WB_RSP_TIMEOUT);

    // Next-state and IF-facing outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned, which would infer a latch.
        state_d             = state_q;
        instruction_o       = NOP_INST;
        inst_access_fault_o = 1'b0;
        stall_o             = 1'b0;
        load_addr           = 1'b0;
        capture             = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (req_ok) begin
                    stall_o   = 1'b1;
                    load_addr = 1'b1;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall_o = 1'b1;
                if (flush_i) begin
                    if (rsp_event) begin
                        stall_o = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DISCARD;
                    end
                end else if (rsp_event) begin
                    if (fetch_en_i) begin
                        stall_o             = 1'b0;
                        instruction_o       = rsp_inst;
                        inst_access_fault_o = rsp_fault;
                        state_d             = ST_IDLE;
                    end else begin
                        capture = 1'b1;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_DISCARD: begin
                stall_o = 1'b1;
                if (rsp_event) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    instruction_o       = buf_inst_q;
                    inst_access_fault_o = buf_fault_q;
                    stall_o             = !fetch_en_i;
                    if (fetch_en_i) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // While reset is held the IF stage sees a quiet NOP source.
        if (rst_i) begin
            state_d             = ST_IDLE;
            instruction_o       = NOP_INST;
            inst_access_fault_o = 1'b0;
            stall_o             = 1'b0;
            load_addr           = 1'b0;
            capture             = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus address is latched at request time and held for the whole cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            addr_q <= '0;
        end else if (load_addr) begin
            addr_q <= pc_i;
        end
    end

    // Buffer for a word that arrived while the consumer was stalled.
    always_ff @(posedge clk_i) begin
        // NOTE: this single-entry buffer is reset (unlike a RAM array) so a
        // stale word can never be presented as a valid fetch.
        if (rst_i) begin
            buf_inst_q  <= NOP_INST;
            buf_fault_q <= 1'b0;
        end else if (capture) begin
            buf_inst_q  <= rsp_inst;
            buf_fault_q <= rsp_fault;
        end
    end

    assign iport_addr_o = addr_q;
    assign iport_cyc_o  = bus_active;
    assign iport_stb_o  = bus_active;

endmodule

// File: tb/tb_titan_imem_port.sv
// Self-checking bench for titan_imem_port. Each fetch is described as a
// transaction (response kind, response cycle, consumer stall length) and the
// expected cycle-by-cycle view is derived from those parameters.
module tb_titan_imem_port;

    localparam int unsigned TO  = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // response kinds for a transaction
    localparam int K_ACK  = 0;
    localparam int K_ERR  = 1;
    localparam int K_BOTH = 2;
    localparam int K_NONE = 3;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic        fetch_en_i;
    logic        flush_i;
    logic [31:0] instruction_o;
    logic        inst_access_fault_o;
    logic        stall_o;
    logic [31:0] iport_addr_o;
    logic        iport_cyc_o;
    logic        iport_stb_o;
    logic [31:0] iport_dat_i;
    logic        iport_ack_i;
    logic        iport_err_i;

    int total = 0;
    int bad   = 0;

    titan_imem_port #(
        .TIMEOUT_CYCLES (TO),
        .NOP_INST       (NOP)
    ) dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .pc_i                (pc_i),
        .fetch_en_i          (fetch_en_i),
        .flush_i             (flush_i),
        .instruction_o       (instruction_o),
        .inst_access_fault_o (inst_access_fault_o),
        .stall_o             (stall_o),
        .iport_addr_o        (iport_addr_o),
        .iport_cyc_o         (iport_cyc_o),
        .iport_stb_o         (iport_stb_o),
        .iport_dat_i         (iport_dat_i),
        .iport_ack_i         (iport_ack_i),
        .iport_err_i         (iport_err_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        rst_i       = 1'b0;
        fetch_en_i  = 1'b0;
        flush_i     = 1'b0;
        iport_ack_i = 1'b0;
        iport_err_i = 1'b0;
    endtask

    // Back-in-idle probe: no bus cycle, no stall, NOP.
    task automatic expect_idle(input string tag);
        idle_inputs();
        #3;
        check_bit({tag, "_cyc"}, iport_cyc_o, 1'b0);
        check_bit({tag, "_stall"}, stall_o, 1'b0);
        check({tag, "_inst"}, instruction_o, NOP);
        tick();
    endtask

    // One fetch. The response comes ack_idx cycles into the bus cycle (or at
    // the timeout cycle TO-1 if the slave stays silent); the consumer then
    // stays stalled for hold_n further cycles before taking the word.
    task automatic run_fetch(input logic [31:0] pc, input int kind, input int ack_idx,
                             input int hold_n, input logic [31:0] data);
        int          resp_idx;
        logic [31:0] exp_inst;
        logic        exp_fault;
        resp_idx  = (kind == K_NONE) ? int'(TO) - 1 : ack_idx;
        exp_inst  = (kind == K_ACK) ? data : NOP;
        exp_fault = (kind != K_ACK);

        idle_inputs();
        pc_i        = pc;
        fetch_en_i  = 1'b1;
        iport_dat_i = $urandom;
        #3;
        check_bit("req_stall", stall_o, 1'b1);
        check_bit("req_cyc_low", iport_cyc_o, 1'b0);
        tick();

        for (int i = 0; i <= resp_idx; i++) begin
            pc_i        = $urandom;
            iport_dat_i = (i == resp_idx) ? data : $urandom;
            iport_ack_i = (i == resp_idx) && (kind == K_ACK || kind == K_BOTH);
            iport_err_i = (i == resp_idx) && (kind == K_ERR || kind == K_BOTH);
            fetch_en_i  = (i == resp_idx) ? (hold_n == 0) : 1'($urandom_range(0, 1));
            #3;
            check_bit("wait_cyc", iport_cyc_o, 1'b1);
            check_bit("wait_stb", iport_stb_o, 1'b1);
            check("wait_addr", iport_addr_o, pc);
            if (i < resp_idx) begin
                check_bit("wait_stall", stall_o, 1'b1);
            end else if (hold_n == 0) begin
                check_bit("rsp_stall", stall_o, 1'b0);
                check("rsp_inst", instruction_o, exp_inst);
                check_bit("rsp_fault", inst_access_fault_o, exp_fault);
            end else begin
                check_bit("rsp_held_stall", stall_o, 1'b1);
            end
            tick();
        end
        iport_ack_i = 1'b0;
        iport_err_i = 1'b0;

        if (hold_n > 0) begin
            for (int h = 0; h < hold_n; h++) begin
                fetch_en_i = 1'b0;
                pc_i       = $urandom;
                #3;
                check_bit("hold_cyc", iport_cyc_o, 1'b0);
                check_bit("hold_stall", stall_o, 1'b1);
                check("hold_inst", instruction_o, exp_inst);
                check_bit("hold_fault", inst_access_fault_o, exp_fault);
                tick();
            end
            fetch_en_i = 1'b1;
            #3;
            check_bit("release_stall", stall_o, 1'b0);
            check("release_inst", instruction_o, exp_inst);
            check_bit("release_fault", inst_access_fault_o, exp_fault);
            tick();
        end
        expect_idle("after_fetch");
    endtask

    // Fetch that is flushed flush_at cycles into the bus cycle. The slave
    // answers at ack_idx (or never, if beyond the timeout); everything seen
    // from the flush onwards must be a stalled NOP with no fault.
    task automatic run_flush(input logic [31:0] pc, input int flush_at, input int ack_idx);
        int resp_idx;
        resp_idx = (ack_idx > int'(TO) - 1) ? int'(TO) - 1 : ack_idx;

        idle_inputs();
        pc_i       = pc;
        fetch_en_i = 1'b1;
        #3;
        check_bit("fl_req_stall", stall_o, 1'b1);
        tick();

        for (int i = 0; i <= resp_idx; i++) begin
            flush_i     = (i == flush_at) ? 1'b1 : ((i > flush_at) ? 1'($urandom_range(0, 1)) : 1'b0);
            fetch_en_i  = 1'($urandom_range(0, 1));
            iport_dat_i = $urandom;
            iport_ack_i = (i == ack_idx);
            iport_err_i = (i == ack_idx) && 1'($urandom_range(0, 1));
            #3;
            check_bit("fl_cyc", iport_cyc_o, 1'b1);
            check_bit("fl_stall", stall_o, 1'b1);
            if (i > flush_at) begin
                check("discard_inst", instruction_o, NOP);
                check_bit("discard_fault", inst_access_fault_o, 1'b0);
            end
            tick();
        end
        expect_idle("after_discard");
    endtask

    // Response coinciding with a flush, either straight in the bus cycle or
    // while the word sits in the hold buffer.
    task automatic run_flush_resp(input logic [31:0] pc, input bit in_hold);
        idle_inputs();
        pc_i       = pc;
        fetch_en_i = 1'b1;
        #3;
        tick();

        iport_dat_i = $urandom | 32'h8000_0000;
        iport_ack_i = 1'b1;
        if (in_hold) begin
            fetch_en_i = 1'b0;
            #3;
            check_bit("fr_capture_stall", stall_o, 1'b1);
            tick();
            iport_ack_i = 1'b0;
        end
        flush_i    = 1'b1;
        fetch_en_i = 1'($urandom_range(0, 1));
        #3;
        check("fr_inst", instruction_o, NOP);
        check_bit("fr_fault", inst_access_fault_o, 1'b0);
        check_bit("fr_stall", stall_o, 1'b0);
        tick();
        expect_idle("after_flush_resp");
    endtask

    initial begin
        logic [31:0] rpc;
        int          kind;
        int          fat;

        idle_inputs();
        rst_i       = 1'b1;
        pc_i        = 32'h0;
        iport_dat_i = 32'h0;

        // reset state
        #3;
        check("rst_inst", instruction_o, NOP);
        check_bit("rst_fault", inst_access_fault_o, 1'b0);
        check_bit("rst_stall", stall_o, 1'b0);
        tick();
        tick();
        rst_i = 1'b0;
        #3;
        check_bit("post_rst_cyc", iport_cyc_o, 1'b0);
        check("post_rst_addr", iport_addr_o, 32'h0);
        check_bit("post_rst_stall", stall_o, 1'b0);
        tick();

        // misaligned PC: no request, NOP, no stall, no fault
        pc_i       = 32'h0000_0102;
        fetch_en_i = 1'b1;
        #3;
        check_bit("mis_stall", stall_o, 1'b0);
        check("mis_inst", instruction_o, NOP);
        check_bit("mis_fault", inst_access_fault_o, 1'b0);
        tick();
        #3;
        check_bit("mis_cyc", iport_cyc_o, 1'b0);
        tick();

        // consumer disabled or flushing: no request
        pc_i       = 32'h0000_0200;
        fetch_en_i = 1'b0;
        #3;
        check_bit("noen_stall", stall_o, 1'b0);
        tick();
        fetch_en_i = 1'b1;
        flush_i    = 1'b1;
        #3;
        check_bit("idle_flush_stall", stall_o, 1'b0);
        check_bit("noen_cyc", iport_cyc_o, 1'b0);
        tick();
        #3;
        check_bit("idle_flush_cyc", iport_cyc_o, 1'b0);
        tick();

        // directed transactions
        run_fetch(32'h0000_0100, K_ACK, 0, 0, 32'h0050_0093);
        run_fetch(32'h0000_0104, K_ERR, 1, 0, 32'hDEAD_BEEF);
        run_fetch(32'h0000_0108, K_NONE, 0, 0, 32'h1234_5678);
        run_flush(32'h0000_010C, 0, 3);
        run_fetch(32'h0000_0110, K_ACK, 0, 3, 32'hCAFE_F00D);
        run_flush_resp(32'h0000_0114, 1'b0);
        run_flush_resp(32'h0000_0118, 1'b1);
        run_fetch(32'h0000_011C, K_BOTH, 1, 1, 32'hA5A5_A5A5);
        run_fetch(32'h0000_0120, K_NONE, 0, 2, 32'h0);

        // reset in the middle of a bus cycle; a late ack must be ignored
        idle_inputs();
        pc_i       = 32'h0000_0124;
        fetch_en_i = 1'b1;
        #3;
        tick();
        #3;
        check_bit("mid_cyc_open", iport_cyc_o, 1'b1);
        rst_i = 1'b1;
        #2;
        check("mid_rst_inst", instruction_o, NOP);
        check_bit("mid_rst_stall", stall_o, 1'b0);
        tick();
        idle_inputs();
        iport_ack_i = 1'b1;
        iport_dat_i = 32'h0BAD_0BAD;
        #3;
        check_bit("mid_rst_cyc", iport_cyc_o, 1'b0);
        check("mid_rst_addr", iport_addr_o, 32'h0);
        check_bit("late_ack_stall", stall_o, 1'b0);
        check("late_ack_inst", instruction_o, NOP);
        check_bit("late_ack_fault", inst_access_fault_o, 1'b0);
        tick();
        expect_idle("after_late_ack");

        // randomized transactions
        for (int n = 0; n < 24; n++) begin
            rpc       = $urandom;
            rpc[1:0]  = 2'b00;
            kind      = $urandom_range(0, 3);
            run_fetch(rpc, kind, $urandom_range(0, TO - 2),
                      ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3), $urandom);
        end
        for (int n = 0; n < 8; n++) begin
            rpc      = $urandom;
            rpc[1:0] = 2'b00;
            fat      = $urandom_range(0, 1);
            run_flush(rpc, fat, $urandom_range(fat + 1, TO + 1));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
